btn_num_ctrl: RTL
=================

BTN_NUM_CTRL -- requirements
Module: btn_num_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 20000: consecutive stable synchronized cycles required to accept a button level change.
REQ-002 Parameter REPEAT_DLY, default 500000: held-button cycles before the first auto-repeat event (auto-repeat builds only).
REQ-003 Parameter REPEAT_PER, default 100000: cycles between subsequent auto-repeat events (auto-repeat builds only).
REQ-004 Port clk, input, 1: sole clock; all state changes on posedge clk.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port buttons, input, 8: raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 Port num, output, 16: unsigned display value, always within 0..9999; feeds the seven-segment driver's num input.
REQ-008 Port strobe, output, 1: one-cycle pulse, high in exactly the cycle a new num value is first presented.

Function
REQ-009 Button map: [0] +1, [1] -1, [2] +10, [3] -10, [4] clear to 0; buttons[7:5] SHALL be ignored.
REQ-010 Each of buttons[4:0] SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each button SHALL have an independent debounce counter, at least 20 bits wide.
REQ-012 Counter behaviour when the synchronized level equals the debounced level: clear to 0.
REQ-013 Counter behaviour when the levels differ: increment by 1.
REQ-014 When the counter reaches DEBOUNCE_CNT-1 while the levels still differ, the debounced level SHALL take the synchronized level and the counter SHALL clear.
REQ-015 A glitch shorter than DEBOUNCE_CNT cycles SHALL produce no event.
REQ-016 A press event SHALL be generated on each debounced released->pressed transition; release transitions SHALL generate no event.
REQ-017 Latency: a raw press held stable from cycle 0 SHALL update num, with strobe high, at cycle DEBOUNCE_CNT+3.
REQ-018 Arithmetic SHALL be modulo 10000: 9999+1 -> 0; 0-1 -> 9999; 9995+10 -> 5; 3-10 -> 9993.
REQ-019 At most one event SHALL be applied per cycle; priority is clear > +10 > -10 > +1 > -1.
REQ-020 Lower-priority events arriving in the same cycle as a higher-priority event SHALL be discarded, not queued.
REQ-021 A clear event SHALL assert strobe even when num is already 0.
REQ-022 Outside event cycles, num SHALL hold its value and strobe SHALL be 0.

Reset
REQ-023 While reset is low: num=0, strobe=0, all synchronizer flops=1 (released), all debounced levels=released, all counters=0.
REQ-024 A press in progress when reset asserts SHALL be lost; after reset deasserts, a button already held low SHALL produce one press event after full debounce.
REQ-025 Reset deassertion SHALL itself produce no strobe.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN defined: +1 and -1 buttons (only) SHALL auto-repeat while their debounced level stays pressed.
REQ-027 With the macro, the first repeat event SHALL occur REPEAT_DLY cycles after the initial press event.
REQ-028 With the macro, subsequent repeat events SHALL occur every REPEAT_PER cycles until release.
REQ-029 With the macro, repeat events SHALL obey the REQ-019 priority, and a release SHALL stop repeats within 1 cycle of the debounced release.
REQ-030 With the macro, a clear or +/-10 event SHALL restart the repeat timer of a held +1/-1 button at REPEAT_DLY.
REQ-031 Macro BTN_AUTOREPEAT_EN undefined: no repeat logic or timers SHALL be synthesized; each press yields exactly one event.

Verification (DEBOUNCE_CNT=4, REPEAT_DLY=10, REPEAT_PER=3)
REQ-032 Hold buttons[0] low from cycle 0 -> num 0->1 with single strobe at cycle 7; no further strobe while held (macro off).
REQ-033 Pulse buttons[1] low for 3 cycles -> no strobe, num stays 0; then hold low 6 cycles from num=0 -> num=9999.
REQ-034 num=9995, press buttons[2] -> num=5; num=3, press buttons[3] -> num=9993.
REQ-035 buttons[4] and buttons[0] driven low in the same cycle from num=42 -> one strobe, num=0; buttons[7:5] toggling -> no strobe.
REQ-036 Macro on, hold buttons[0] 40 cycles from num=0 -> strobes at cycles 7, 17, 20, 23, ...; num increments once per strobe; stops within 1 cycle of debounced release.
REQ-037 Assert reset mid-debounce of buttons[0] with button still held -> num=0, strobe=0 during reset; exactly one strobe DEBOUNCE_CNT+3 cycles after deassertion.

Source files
------------

// File: rtl/btn_num_ctrl.sv
// Debounced push-button front end driving a modulo-10000 display counter.
// Optional build macro BTN_AUTOREPEAT_EN adds auto-repeat on the +1/-1 buttons.
module btn_num_ctrl #(
  parameter int DEBOUNCE_CNT = 20000,
  parameter int REPEAT_DLY   = 500000,
  parameter int REPEAT_PER   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  buttons,
  output logic [15:0] num,
  output logic        strobe
);

  localparam int CW = ($clog2(DEBOUNCE_CNT) > 20) ? $clog2(DEBOUNCE_CNT) : 20;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  localparam int B_INC1  = 0;
  localparam int B_DEC1  = 1;
  localparam int B_INC10 = 2;
  localparam int B_DEC10 = 3;
  localparam int B_CLR   = 4;

  logic [4:0]    sync1, sync2;
  logic [4:0]    db, db_prev, press;
  logic [CW-1:0] cnt [5];
  logic [4:0]    evt;
  logic [15:0]   next_num;
  logic          apply;

  logic unused_buttons;
  assign unused_buttons = ^buttons[7:5];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= buttons[4:0];
      sync2 <= sync1;
    end
  end

  // NOTE: the counter array is only five registers, so it is reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '1;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Released->pressed edge of the debounced level, registered once more.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_prev <= '1;
      press   <= '0;
    end else begin
      db_prev <= db;
      press   <= db_prev & ~db;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PER - 1);

  logic [RW-1:0] rpt_tmr [2];
  logic [1:0]    armed, rpt;
  logic          big_evt;

  assign big_evt = |press[4:2];

  always_comb begin
    for (int i = 0; i < 2; i++)
      rpt[i] = armed[i] & ~db[i] & (rpt_tmr[i] == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed <= '0;
      for (int i = 0; i < 2; i++) rpt_tmr[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (db[i]) begin
          armed[i]   <= 1'b0;
          rpt_tmr[i] <= '0;
        end else if (press[i]) begin
          armed[i]   <= 1'b1;
          rpt_tmr[i] <= DLY_LOAD;
        end else if (armed[i]) begin
          if (big_evt)               rpt_tmr[i] <= DLY_LOAD;
          else if (rpt_tmr[i] == '0) rpt_tmr[i] <= PER_LOAD;
          else                       rpt_tmr[i] <= rpt_tmr[i] - 1'b1;
        end
      end
    end
  end

  assign evt = {press[4:2], press[1:0] | rpt};
`else
  localparam int unused_rpt_params = REPEAT_DLY + REPEAT_PER;
  assign evt = press;
`endif

  // NOTE: next_num and apply get defaults first so no latch is inferred.
  always_comb begin
    next_num = num;
    apply    = 1'b1;
    if (evt[B_CLR])
      next_num = '0;
    else if (evt[B_INC10])
      next_num = (num >= 16'd9990) ? num - 16'd9990 : num + 16'd10;
    else if (evt[B_DEC10])
      next_num = (num < 16'd10) ? num + 16'd9990 : num - 16'd10;
    else if (evt[B_INC1])
      next_num = (num == 16'd9999) ? 16'd0 : num + 16'd1;
    else if (evt[B_DEC1])
      next_num = (num == 16'd0) ? 16'd9999 : num - 16'd1;
    else
      apply = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num    <= '0;
      strobe <= 1'b0;
    end else begin
      num    <= next_num;
      strobe <= apply;
    end
  end

endmodule
